rtclock_pps_gen: RTL and testbench

- Time-to-event generator. It is the output side of the real-time clock: it consumes the free-running sec/nsec timebase and produces events from it.
- Outputs:
  - a periodic PPS pulse with programmable phase offset and width.
  - a one-shot scheduled trigger at an absolute {sec,nsec} time, loaded through a valid/ready handshake.
- Sits in the clk domain beside the rtclock. Drives board PPS-out pins and timestamped-test-start logic.

---
 rtl/rtclock_pps_gen.sv | 203 ++++++++++++++++++++
 tb/tb_rtclock_pps_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtclock_pps_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rtclock_pps_gen
// Description : Time-to-event generator fed by the free-running sec/nsec
//               timebase. Produces a periodic PPS pulse (programmable phase
//               and width) and a one-shot trigger at an absolute time.
// Revision    : 1.0 - initial release
// ============================================================================
module rtclock_pps_gen #(
  parameter int unsigned C_CLK_TO_NS_RATIO = 8,
  parameter int unsigned C_NSEC_MODULO     = 1000000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] sec,
  input  logic [29:0] nsec,
  input  logic        pps_enable,
  input  logic [29:0] pps_offset,
  input  logic [29:0] pps_width,
  input  logic [47:0] trig_sec,
  input  logic [29:0] trig_nsec,
  input  logic        trig_valid,
  output logic        trig_ready,
  input  logic        trig_cancel,
  output logic        pps_out,
  output logic [31:0] pps_count,
  output logic        trig_out,
  output logic        trig_late
);

  // Per-clock nanosecond step and the pulse-width ceiling (half a second),
  // which guarantees the pulse ends before the next second's event.
  localparam logic [29:0] C_RATIO    = 30'(C_CLK_TO_NS_RATIO);
  localparam logic [29:0] C_HALF_SEC = 30'(C_NSEC_MODULO / 2);

  localparam logic [0:0] P_IDLE  = 1'b0;
  localparam logic [0:0] P_HIGH  = 1'b1;

  localparam logic [0:0] T_IDLE  = 1'b0;
  localparam logic [0:0] T_ARMED = 1'b1;

  // --------------------------------------------------------------------------
  // PPS event detection
  // --------------------------------------------------------------------------
  logic        prev_valid_q;
  logic        ge_prev_q;
  logic [47:0] sec_prev_q;
  logic        w_ge;
  logic        w_pps_event;

  // The event is the rising edge of "nsec has reached the offset" or a new
  // second already past the offset (covers offset 0 and timebase reloads).
  assign w_ge        = (nsec >= pps_offset);
  assign w_pps_event = prev_valid_q & w_ge & (~ge_prev_q | (sec != sec_prev_q));

  // Remember the previous timebase sample for the edge-style comparison
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid_q <= 1'b0;
      ge_prev_q    <= 1'b0;
      sec_prev_q   <= '0;
    end else begin
      prev_valid_q <= 1'b1;
      ge_prev_q    <= w_ge;
      sec_prev_q   <= sec;
    end
  end

  // --------------------------------------------------------------------------
  // PPS pulse FSM
  // --------------------------------------------------------------------------
  logic [0:0]  pps_state_q, pps_state_d;
  logic [29:0] rem_q, rem_d;
  logic [31:0] pps_count_q, pps_count_d;
  logic [29:0] w_width_clamped;

  assign w_width_clamped = (pps_width > C_HALF_SEC) ? C_HALF_SEC : pps_width;

  // PPS state register plus remaining-high-time and pulse counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pps_state_q <= P_IDLE;
      rem_q       <= '0;
      pps_count_q <= '0;
    end else begin
      pps_state_q <= pps_state_d;
      rem_q       <= rem_d;
      pps_count_q <= pps_count_d;
    end
  end

  // PPS next state: start on a qualified event, count down the high time
  always_comb begin
    pps_state_d = pps_state_q;
    rem_d       = rem_q;
    pps_count_d = pps_count_q;
    if (!pps_enable) begin
      // Disabling cuts any pulse short; the counter keeps its value.
      pps_state_d = P_IDLE;
    end else begin
      case (pps_state_q)
        P_IDLE: begin
          if (w_pps_event) begin
            pps_state_d = P_HIGH;
            rem_d       = w_width_clamped;
            pps_count_d = pps_count_q + 32'd1;
          end
        end
        P_HIGH: begin
          // Events while high are dropped; the last high cycle is the one
          // in which at most one clock's worth of ns remains.
          if (rem_q <= C_RATIO) begin
            pps_state_d = P_IDLE;
          end else begin
            rem_d = rem_q - C_RATIO;
          end
        end
        default: pps_state_d = P_IDLE;
      endcase
    end
  end

  // PPS outputs decoded from state
  always_comb begin
    pps_out   = (pps_state_q == P_HIGH);
    pps_count = pps_count_q;
  end

  // --------------------------------------------------------------------------
  // Scheduled trigger FSM
  // --------------------------------------------------------------------------
  logic [0:0]  trig_state_q, trig_state_d;
  logic [77:0] tgt_q, tgt_d;
  logic        late_q, late_d;
  logic        trig_out_q, trig_out_d;
  logic        trig_late_q, trig_late_d;
  logic [77:0] w_now;
  logic [77:0] w_req;
  logic        w_req_late;
  logic        w_match;

  // With nsec below the modulo, the concatenation orders times correctly.
  assign w_now      = {sec, nsec};
  assign w_req      = {trig_sec, trig_nsec};
  assign w_req_late = (w_req < w_now);
  assign w_match    = (w_now >= tgt_q);

  // Trigger state register, latched target and registered one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_state_q <= T_IDLE;
      tgt_q        <= '0;
      late_q       <= 1'b0;
      trig_out_q   <= 1'b0;
      trig_late_q  <= 1'b0;
    end else begin
      trig_state_q <= trig_state_d;
      tgt_q        <= tgt_d;
      late_q       <= late_d;
      trig_out_q   <= trig_out_d;
      trig_late_q  <= trig_late_d;
    end
  end

  // Trigger next state: accept when idle, fire or cancel when armed
  always_comb begin
    trig_state_d = trig_state_q;
    tgt_d        = tgt_q;
    late_d       = late_q;
    trig_out_d   = 1'b0;
    trig_late_d  = 1'b0;
    case (trig_state_q)
      T_IDLE: begin
        if (trig_valid) begin
          trig_state_d = T_ARMED;
          tgt_d        = w_req;
          late_d       = w_req_late;
        end
      end
      T_ARMED: begin
        // Cancel beats a coincident match so no stray pulse escapes.
        if (trig_cancel) begin
          trig_state_d = T_IDLE;
        end else if (w_match) begin
          trig_state_d = T_IDLE;
          trig_out_d   = 1'b1;
          trig_late_d  = late_q;
        end
      end
      default: trig_state_d = T_IDLE;
    endcase
  end

  // Trigger outputs; ready simply reflects that nothing is armed
  always_comb begin
    trig_ready = (trig_state_q == T_IDLE);
    trig_out   = trig_out_q;
    trig_late  = trig_late_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rtclock_pps_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rtclock_pps_gen
// Description : Self-checking bench for rtclock_pps_gen with a scaled second
//               (8000 ns) so full PPS periods fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtclock_pps_gen;

  localparam longint RATIO = 8;
  localparam longint MOD   = 8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic        pps_enable;
  logic [29:0] pps_offset;
  logic [29:0] pps_width;
  logic [47:0] trig_sec;
  logic [29:0] trig_nsec;
  logic        trig_valid;
  logic        trig_ready;
  logic        trig_cancel;
  logic        pps_out;
  logic [31:0] pps_count;
  logic        trig_out;
  logic        trig_late;

  rtclock_pps_gen #(
    .C_CLK_TO_NS_RATIO(32'(RATIO)),
    .C_NSEC_MODULO    (32'(MOD))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sec        (sec),
    .nsec       (nsec),
    .pps_enable (pps_enable),
    .pps_offset (pps_offset),
    .pps_width  (pps_width),
    .trig_sec   (trig_sec),
    .trig_nsec  (trig_nsec),
    .trig_valid (trig_valid),
    .trig_ready (trig_ready),
    .trig_cancel(trig_cancel),
    .pps_out    (pps_out),
    .pps_count  (pps_count),
    .trig_out   (trig_out),
    .trig_late  (trig_late)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (time kept as a linear ns count)
  bit          m_prev_valid;
  bit          m_ge_prev;
  logic [47:0] m_sec_prev;
  int          m_high_left;
  int unsigned m_count;
  bit          m_armed;
  bit          m_late;
  longint      m_tgt;
  bit          e_trig_out;
  bit          e_trig_late;

  // Bench-side observations for directed checks
  int          hi_cnt;
  bit          pps_seen;
  logic [47:0] rise_sec;
  logic [29:0] rise_nsec;
  logic [47:0] fire_sec;
  logic [29:0] fire_nsec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int high_cycles(input logic [29:0] w);
    longint wc;
    longint n;
    wc = (longint'(w) > MOD / 2) ? MOD / 2 : longint'(w);
    n  = (wc + RATIO - 1) / RATIO;
    return int'((n < 1) ? 1 : n);
  endfunction

  function automatic longint lin(input logic [47:0] s, input logic [29:0] n);
    return longint'(s) * MOD + longint'(n);
  endfunction

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_step();
    bit     ge;
    bit     ev;
    longint now;
    longint req;
    if (reset) begin
      m_prev_valid = 0; m_ge_prev = 0; m_sec_prev = '0;
      m_high_left  = 0; m_count   = 0;
      m_armed      = 0; m_late    = 0; m_tgt = 0;
      e_trig_out   = 0; e_trig_late = 0;
    end else begin
      now = lin(sec, nsec);
      req = lin(trig_sec, trig_nsec);
      ge  = (nsec >= pps_offset);
      ev  = m_prev_valid && ge && (!m_ge_prev || (sec != m_sec_prev));
      if (!pps_enable)          m_high_left = 0;
      else if (m_high_left > 0) m_high_left--;
      else if (ev) begin
        m_high_left = high_cycles(pps_width);
        m_count++;
      end
      e_trig_out  = 0;
      e_trig_late = 0;
      if (m_armed) begin
        if (trig_cancel) m_armed = 0;
        else if (now >= m_tgt) begin
          e_trig_out  = 1;
          e_trig_late = m_late;
          m_armed     = 0;
        end
      end else if (trig_valid) begin
        m_armed = 1;
        m_tgt   = req;
        m_late  = (req < now);
      end
      m_prev_valid = 1;
      m_ge_prev    = ge;
      m_sec_prev   = sec;
    end
  endtask

  // One clock: model, edge, compare all outputs, then advance the timebase
  task automatic tick();
    logic [47:0] s0;
    logic [29:0] n0;
    longint      n;
    s0 = sec;
    n0 = nsec;
    model_step();
    @(posedge clk);
    #1;
    chk("pps_out",    64'(pps_out),    64'(m_high_left > 0));
    chk("pps_count",  64'(pps_count),  64'(m_count));
    chk("trig_out",   64'(trig_out),   64'(e_trig_out));
    chk("trig_late",  64'(trig_late),  64'(e_trig_late));
    chk("trig_ready", 64'(trig_ready), 64'(!m_armed));
    if (pps_out) hi_cnt++;
    if (pps_out && !pps_seen) begin
      rise_sec  = s0;
      rise_nsec = n0;
    end
    pps_seen = pps_out;
    if (trig_out) begin
      fire_sec  = s0;
      fire_nsec = n0;
    end
    n = longint'(nsec) + RATIO;
    if (n >= MOD) begin
      n   = n - MOD;
      sec = sec + 48'd1;
    end
    nsec = 30'(n);
  endtask

  task automatic set_trig_target(input longint t);
    trig_sec  = 48'(t / MOD);
    trig_nsec = 30'(t % MOD);
  endtask

  initial begin
    bit     acc;
    longint t;
    reset = 1'b1; sec = '0; nsec = '0;
    pps_enable = 1'b0; pps_offset = '0; pps_width = '0;
    trig_sec = '0; trig_nsec = '0; trig_valid = 1'b0; trig_cancel = 1'b0;
    hi_cnt = 0; pps_seen = 1'b0;
    rise_sec = '0; rise_nsec = '0; fire_sec = '0; fire_nsec = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_pps_out",    64'(pps_out),    64'd0);
    chk("rst_pps_count",  64'(pps_count),  64'd0);
    chk("rst_trig_ready", 64'(trig_ready), 64'd1);
    chk("rst_trig_out",   64'(trig_out),   64'd0);

    // 1: offset 0, width 800 ns -> 100-cycle pulse on the 5->6 rollover
    reset = 1'b0; pps_enable = 1'b1; pps_offset = '0; pps_width = 30'd800;
    sec = 48'd5; nsec = 30'(MOD - 5 * RATIO);
    hi_cnt = 0;
    repeat (900) tick();
    chk("t1_high_cycles", 64'(hi_cnt),    64'd100);
    chk("t1_rise_sec",    64'(rise_sec),  64'd6);
    chk("t1_rise_nsec",   64'(rise_nsec), 64'd0);
    chk("t1_count",       64'(pps_count), 64'd1);

    // 2: offset mid-second, width 0 -> single-cycle pulse, none at rollover
    sec = 48'd6; nsec = 30'd7200;
    pps_offset = 30'd4000; pps_width = '0;
    hi_cnt = 0;
    repeat (1000) tick();
    chk("t2_high_cycles", 64'(hi_cnt),    64'd1);
    chk("t2_rise_sec",    64'(rise_sec),  64'd7);
    chk("t2_rise_nsec",   64'(rise_nsec), 64'd4000);
    chk("t2_count",       64'(pps_count), 64'd2);

    // 3: width above half a second is clamped to half a second
    pps_width = 30'd7200;
    hi_cnt = 0;
    repeat (1200) tick();
    chk("t3_high_cycles", 64'(hi_cnt),    64'd500);
    chk("t3_rise_nsec",   64'(rise_nsec), 64'd4000);
    chk("t3_count",       64'(pps_count), 64'd3);
    chk("t3_low_after",   64'(pps_out),   64'd0);

    // 4: on-time trigger at {10,800}
    pps_enable = 1'b0;
    sec = 48'd10; nsec = '0;
    trig_sec = 48'd10; trig_nsec = 30'd800; trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    chk("t4_ready_low", 64'(trig_ready), 64'd0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (trig_out) break;
    end
    chk("t4_fired",     64'(trig_out),  64'd1);
    chk("t4_fire_nsec", 64'(fire_nsec), 64'd800);
    chk("t4_late",      64'(trig_late), 64'd0);
    chk("t4_ready",     64'(trig_ready), 64'd1);

    // 5: target already past at acceptance -> late pulse right away
    sec = 48'd10; nsec = 30'd1000;
    trig_sec = 48'd9; trig_nsec = '0; trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    tick();
    chk("t5_fired", 64'(trig_out),  64'd1);
    chk("t5_late",  64'(trig_late), 64'd1);

    // 6a: cancel coincident with the match suppresses the pulse
    sec = 48'd19; nsec = 30'(MOD - 10 * RATIO);
    trig_sec = 48'd20; trig_nsec = '0; trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sec == 48'd20 && nsec == 30'd0) break;
      tick();
    end
    chk("t6_still_armed", 64'(trig_ready), 64'd0);
    trig_cancel = 1'b1;
    tick();
    trig_cancel = 1'b0;
    chk("t6_no_fire", 64'(trig_out),   64'd0);
    chk("t6_ready",   64'(trig_ready), 64'd1);
    repeat (3) tick();

    // 6b: reset in the middle of a pulse, then no event on first sample
    pps_enable = 1'b1; pps_offset = '0; pps_width = 30'd800;
    sec = 48'd30; nsec = 30'(MOD - RATIO);
    repeat (5) tick();
    chk("t6_pps_high", 64'(pps_out), 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_pps",   64'(pps_out),   64'd0);
    chk("t6_rst_count", 64'(pps_count), 64'd0);
    reset = 1'b0;
    sec = 48'd40; nsec = '0;
    tick();
    chk("t6_no_first_event", 64'(pps_out), 64'd0);
    tick();
    chk("t6_no_second_event", 64'(pps_out), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 1999) == 0) pps_enable = ~pps_enable;
      if ($urandom_range(0, 499) == 0) begin
        pps_offset = 30'($urandom_range(0, 32'(MOD - 1)));
        pps_width  = 30'($urandom_range(0, 32'(MOD)));
      end
      if ($urandom_range(0, 699) == 0) begin
        sec  = 48'($urandom_range(0, 100));
        nsec = 30'($urandom_range(0, 32'(MOD - 1)));
      end
      if (!trig_valid && $urandom_range(0, 49) == 0) begin
        t = lin(sec, nsec) + longint'($urandom_range(0, 3000)) - 500;
        if (t < 0) t = 0;
        set_trig_target(t);
        trig_valid = 1'b1;
      end
      trig_cancel = ($urandom_range(0, 299) == 0);
      acc = trig_valid && trig_ready && !reset;
      tick();
      if (acc) trig_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
